// File: rtl/seg_disp_ctrl.sv
// Multiplexed 7-segment display controller: scans NDIG digits showing either the live
// operand or a held operation result, with optional leading-zero blanking.
module seg_disp_ctrl #(
   parameter int NDIG        = 4,
   parameter int NOPS        = 4,
   parameter int REFRESH_DIV = 100000,
   parameter bit BLANK_LZ    = 1'b0
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [NOPS-1:0]                           op_sel,
   input  logic [NOPS*NDIG*7-1:0]                    op_seg,
   input  logic [NOPS-1:0]                           op_neg,
   input  logic [NDIG*7-1:0]                         num_seg,
   input  logic                                      num_load,
   output logic [6:0]                                seg,
   output logic [NDIG-1:0]                           an,
   output logic [((NDIG > 1) ? $clog2(NDIG) : 1)-1:0] digit_idx,
   output logic                                      is_original
);

   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   localparam logic [6:0] SEG_ZERO  = 7'b1000000;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   logic [PW-1:0] prescale;
   logic          refresh_wrap;
   logic [6:0]    hold_buf  [NDIG];
   logic [6:0]    op_digits [NDIG];
   logic          op_hit;
   logic [6:0]    live      [NDIG];
   logic [6:0]    shown     [NDIG];
   logic          lead_zero;

   assign refresh_wrap = (prescale == PW'(REFRESH_DIV - 1));

   // Scanning channels downward lets the lowest requesting index overwrite any higher one.
   always_comb begin
      op_hit = 1'b0;
      for (int d = 0; d < NDIG; d++) begin
         op_digits[d] = SEG_BLANK;
      end
      for (int k = NOPS - 1; k >= 0; k--) begin
         if (op_sel[k]) begin
            op_hit = 1'b1;
            for (int d = 0; d < NDIG; d++) begin
               op_digits[d] = op_seg[(k*NDIG + d)*7 +: 7];
            end
            if (op_neg[k]) begin
               op_digits[NDIG-1] = SEG_MINUS;
            end
         end
      end
   end

   always_comb begin
      for (int d = 0; d < NDIG; d++) begin
         if (op_hit) begin
            live[d] = op_digits[d];
         end else if (num_load || is_original) begin
            live[d] = num_seg[d*7 +: 7];
         end else begin
            live[d] = hold_buf[d];
         end
      end
   end

   // Blanking runs from the most significant digit down until a non-zero, non-blank digit.
   always_comb begin
      lead_zero = 1'b1;
      for (int d = NDIG - 1; d >= 0; d--) begin
         shown[d] = live[d];
         if (BLANK_LZ && (d != 0) && lead_zero && (live[d] == SEG_ZERO)) begin
            shown[d] = SEG_BLANK;
         end
         if ((live[d] != SEG_ZERO) && (live[d] != SEG_BLANK)) begin
            lead_zero = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prescale  <= '0;
         digit_idx <= '0;
      end else if (refresh_wrap) begin
         prescale  <= '0;
         digit_idx <= (digit_idx == IW'(NDIG - 1)) ? '0 : digit_idx + IW'(1);
      end else begin
         prescale  <= prescale + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int d = 0; d < NDIG; d++) begin
            hold_buf[d] <= SEG_BLANK;
         end
         is_original <= 1'b1;
      end else if (op_hit) begin
         for (int d = 0; d < NDIG; d++) begin
            hold_buf[d] <= op_digits[d];
         end
         is_original <= 1'b0;
      end else if (num_load) begin
         is_original <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg <= SEG_BLANK;
         an  <= '1;
      end else begin
         seg <= shown[digit_idx];
         an  <= ~(NDIG'(1) << digit_idx);
      end
   end

endmodule

// File: doc/seg_disp_ctrl.md
SEG_DISP_CTRL -- requirements
Module: seg_disp_ctrl

Interface
REQ-001 The block SHALL use one clock, clk, and a synchronous, active-high reset, rst; all state changes occur on the rising edge of clk.
REQ-002 Parameter NDIG, default 4: number of 7-segment digits; legal range 2..8.
REQ-003 Parameter NOPS, default 4: number of operation result channels; legal range 1..8.
REQ-004 Parameter REFRESH_DIV, default 100000: clk cycles per digit strobe; minimum 2.
REQ-005 Parameter BLANK_LZ, default 0: when 1, leading-zero digits are blanked.
REQ-006 clk  in  1  system clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 op_sel  in  NOPS  operation select switches; bit k requests channel k.
REQ-009 op_seg  in  NOPS*NDIG*7  segment patterns, active-low; channel k digit d occupies bits [(k*NDIG+d)*7 +: 7].
REQ-010 op_neg  in  NOPS  negative-result flag per channel.
REQ-011 num_seg  in  NDIG*7  live operand display, active-low; digit d occupies bits [d*7 +: 7].
REQ-012 num_load  in  1  request to show the live operand.
REQ-013 seg  out  7  registered active-low segment drive.
REQ-014 an  out  NDIG  registered active-low anode drive.
REQ-015 digit_idx  out  max(1,clog2(NDIG))  currently strobed digit.
REQ-016 is_original  out  1  registered; 1 when the display tracks num_seg.

Function
REQ-017 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap; on wrap, digit_idx SHALL increment, and wrap from NDIG-1 to 0.
REQ-018 Live source selection, evaluated each cycle, SHALL follow this priority:
- any op_sel bit set: the lowest set index k wins;
- else num_load: num_seg;
- else is_original=1: num_seg;
- else: hold buffer.
REQ-019 When op_sel is nonzero, the block SHALL load the hold buffer with the effective digits of winning channel k and clear is_original on the same edge.
REQ-020 Effective digits of channel k SHALL equal op_seg of channel k, except that digit NDIG-1 is replaced by 7'b0111111 (minus) when op_neg[k]=1.
REQ-021 When op_sel is zero and num_load=1, is_original SHALL be set to 1; the hold buffer is unchanged.
REQ-022 When op_sel is zero and num_load=0, is_original and the hold buffer SHALL retain their values; a held result is not affected by later changes to op_seg or op_neg.
REQ-023 On each edge, seg SHALL load digit digit_idx (pre-edge value) of the live source, and an SHALL load ~(1<<digit_idx); latency from an input change to seg is one cycle.
REQ-024 With BLANK_LZ=1, a digit equal to 7'b1000000 (zero) SHALL output 7'b1111111 when every higher digit is also zero or blank. Digit 0 is never blanked, and a minus digit stops the blanking.
REQ-025 If op_sel changes between two set values, the new winner SHALL overwrite the hold buffer on that edge; there is no lock-out.

Reset
REQ-026 While rst=1, the block SHALL hold the following values, overriding all other inputs, including mid-strobe:
- prescaler=0, digit_idx=0;
- hold buffer all 7'b1111111;
- seg=7'b1111111, an all ones;
- is_original=1.
REQ-027 After rst is released with no requests pending, the display SHALL track num_seg starting at digit 0.

Verification (NDIG=4, NOPS=4, REFRESH_DIV=4, BLANK_LZ=0)
REQ-028 Reset: assert rst for 3 cycles mid-scan -> seg=7'h7F, an=4'b1111, digit_idx=0, is_original=1; the first strobe after release is an=4'b1110.
REQ-029 Refresh wrap: run for 16 cycles -> digit_idx advances every 4 cycles through 0,1,2,3,0; an sequence 1110, 1101, 1011, 0111, 1110.
REQ-030 Priority and sign: op_sel=4'b0110, op_neg=4'b0010 -> channel 1 is shown; digit 3 seg=7'b0111111; is_original=0 one cycle after.
REQ-031 Hold: pulse op_sel=4'b0001 for 1 cycle, then change op_seg channel 0 digit 0 from 7'b1000000 to 7'b1111001 -> digit 0 still shows 7'b1000000 on all later strobes.
REQ-032 Return to operand: pulse num_load with op_sel=0 -> is_original=1; a later num_seg digit 2 change to 7'b0100100 appears on the next digit-2 strobe.
REQ-033 Blanking (BLANK_LZ=1): channel 2 digits = {0,0,4,0} (MSD first), op_sel=4'b0100 -> digits 3 and 2 output 7'h7F; digits 1 and 0 show 4 and 0.
